// File: rtl/capping_station_ctrl.sv
// Capping station sequencer: conveyor control, bottle alignment, cap strobe and bottle count.
// Optional macro REJECT_UNFILLED_EN: CHECK diverts unfilled bottles to RELEASE and counts them.
module capping_station_ctrl #(
    parameter int ALIGN_CYC = 4,
    parameter int CAP_HOLD  = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic       CLKplaca,
    input  logic       reset,
    input  logic       run,
    input  logic       sensor_garrafa,
    input  logic       TemR,
    input  logic       nivel_ok,
    input  logic       clr_falha,
    output logic       motor_esteira,
    output logic       tampar,
    output logic       sem_rolha,
    output logic       falha,
    output logic [7:0] garrafas,
    output logic [2:0] estado
`ifdef REJECT_UNFILLED_EN
    ,
    output logic [7:0] rejeitadas
`endif
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE    = 3'd1,
        S_CHECK   = 3'd2,
        S_CAP     = 3'd3,
        S_HOLD    = 3'd4,
        S_RELEASE = 3'd5,
        S_NO_CORK = 3'd6,
        S_FAULT   = 3'd7
    } state_t;

    localparam logic [3:0] ALIGN_N   = 4'(ALIGN_CYC);
    localparam logic [7:0] HOLD_N    = 8'(CAP_HOLD);
    localparam logic [7:0] TIMEOUT_N = 8'(TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d, timer_inc;
    logic [3:0] align_q, align_d, align_inc;
    logic       tampar_q, sem_rolha_q;
    logic [7:0] garrafas_q, garrafas_d;

`ifdef REJECT_UNFILLED_EN
    logic [7:0] rejeitadas_q, rejeitadas_d;
`else
    logic unused_nivel_ok;
    assign unused_nivel_ok = nivel_ok;
`endif

    always_comb begin
        state_d   = state_q;
        timer_inc = timer_q + 8'd1;
        align_inc = align_q + 4'd1;
        timer_d   = timer_q;
        align_d   = align_q;
        case (state_q)
            S_IDLE: if (run) state_d = S_MOVE;
            S_MOVE: begin
                timer_d = timer_inc;
                align_d = sensor_garrafa ? align_inc : 4'd0;
                if (sensor_garrafa && (align_inc == ALIGN_N)) state_d = S_CHECK;
                else if (timer_inc == TIMEOUT_N)              state_d = S_FAULT;
                else if (!run)                                state_d = S_IDLE;
            end
            S_CHECK: begin
`ifdef REJECT_UNFILLED_EN
                if (!nivel_ok)  state_d = S_RELEASE;
                else if (TemR)  state_d = S_CAP;
                else            state_d = S_NO_CORK;
`else
                state_d = TemR ? S_CAP : S_NO_CORK;
`endif
            end
            S_NO_CORK: if (TemR) state_d = S_CAP;
            S_CAP:     state_d = S_HOLD;
            S_HOLD: begin
                timer_d = timer_inc;
                if (timer_inc == HOLD_N) state_d = S_RELEASE;
            end
            S_RELEASE: begin
                timer_d = timer_inc;
                if (!sensor_garrafa)           state_d = run ? S_MOVE : S_IDLE;
                else if (timer_inc == TIMEOUT_N) state_d = S_FAULT;
            end
            S_FAULT:   if (clr_falha) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
        // Every state starts with a fresh timer and alignment count.
        if (state_d != state_q) begin
            timer_d = 8'd0;
            align_d = 4'd0;
        end
        garrafas_d = garrafas_q + {7'd0, (state_q == S_CAP)};
`ifdef REJECT_UNFILLED_EN
        rejeitadas_d = rejeitadas_q
                     + {7'd0, (state_q == S_CHECK) && (state_d == S_RELEASE)};
`endif
    end

    always_ff @(posedge CLKplaca or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            timer_q     <= 8'd0;
            align_q     <= 4'd0;
            tampar_q    <= 1'b0;
            sem_rolha_q <= 1'b0;
            garrafas_q  <= 8'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            align_q     <= align_d;
            tampar_q    <= (state_d == S_CAP);
            sem_rolha_q <= (state_d == S_NO_CORK);
            garrafas_q  <= garrafas_d;
        end
    end

`ifdef REJECT_UNFILLED_EN
    always_ff @(posedge CLKplaca or posedge reset) begin
        if (reset) rejeitadas_q <= 8'd0;
        else       rejeitadas_q <= rejeitadas_d;
    end
    assign rejeitadas = rejeitadas_q;
`endif

    assign motor_esteira = (state_q == S_MOVE) || (state_q == S_RELEASE);
    assign falha         = (state_q == S_FAULT);
    assign tampar        = tampar_q;
    assign sem_rolha     = sem_rolha_q;
    assign garrafas      = garrafas_q;
    assign estado        = state_q;

endmodule

// File: tb/tb_capping_station_ctrl.sv
// Directed bench for capping_station_ctrl with default parameters (4 / 8 / 200).
module tb_capping_station_ctrl;

  logic       CLKplaca = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       sensor_garrafa = 1'b0;
  logic       TemR = 1'b0;
  logic       nivel_ok = 1'b1;
  logic       clr_falha = 1'b0;
  logic       motor_esteira, tampar, sem_rolha, falha;
  logic [7:0] garrafas;
  logic [2:0] estado;
`ifdef REJECT_UNFILLED_EN
  logic [7:0] rejeitadas;
`endif

  int errors = 0;
  int checks = 0;
  int tampar_cnt = 0;
  int double_cnt = 0;
  int overlap_cnt = 0;
  logic prev_tampar = 1'b0;

  capping_station_ctrl dut (
    .CLKplaca(CLKplaca), .reset(reset), .run(run), .sensor_garrafa(sensor_garrafa),
    .TemR(TemR), .nivel_ok(nivel_ok), .clr_falha(clr_falha),
    .motor_esteira(motor_esteira), .tampar(tampar), .sem_rolha(sem_rolha),
    .falha(falha), .garrafas(garrafas), .estado(estado)
`ifdef REJECT_UNFILLED_EN
    , .rejeitadas(rejeitadas)
`endif
  );

  always #5 CLKplaca = ~CLKplaca;

  // cap strobe monitor, sampled mid-cycle
  always @(negedge CLKplaca) begin
    if (tampar === 1'b1) begin
      tampar_cnt = tampar_cnt + 1;
      if (prev_tampar === 1'b1) double_cnt = double_cnt + 1;
      if (motor_esteira === 1'b1) overlap_cnt = overlap_cnt + 1;
    end
    prev_tampar = tampar;
  end

  task automatic step();
    @(posedge CLKplaca);
    #1;
  endtask

  // From CHECK with TemR=1: cap, hold, release, sensor drop.
  task automatic finish_bottle();
    step();
    checks++; if (estado !== 3'd3 || tampar !== 1'b1 || motor_esteira !== 1'b0) begin errors++; $display("FAIL cap_state: estado=%0d tampar=%b motor=%b expected 3/1/0", estado, tampar, motor_esteira); end
    step();
    checks++; if (estado !== 3'd4 || tampar !== 1'b0) begin errors++; $display("FAIL hold_entry: estado=%0d tampar=%b expected 4/0", estado, tampar); end
    repeat (7) step();
    checks++; if (estado !== 3'd4 || motor_esteira !== 1'b0) begin errors++; $display("FAIL hold_last: estado=%0d motor=%b expected 4/0", estado, motor_esteira); end
    step();
    checks++; if (estado !== 3'd5 || motor_esteira !== 1'b1) begin errors++; $display("FAIL release: estado=%0d motor=%b expected 5/1", estado, motor_esteira); end
    sensor_garrafa = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge CLKplaca);
    #1;
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL reset_estado: got %0d expected 0", estado); end
    checks++; if ({motor_esteira, tampar, sem_rolha, falha} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", {motor_esteira, tampar, sem_rolha, falha}); end
    checks++; if (garrafas !== 8'd0) begin errors++; $display("FAIL reset_garrafas: got %0d expected 0", garrafas); end
    reset = 1'b0;
    step();
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL idle_hold: got %0d expected 0", estado); end
  endtask

  task automatic test_basic_cap();
    run = 1'b1; TemR = 1'b1; sensor_garrafa = 1'b0;
    step();
    checks++; if (estado !== 3'd1 || motor_esteira !== 1'b1) begin errors++; $display("FAIL move_entry: estado=%0d motor=%b expected 1/1", estado, motor_esteira); end
    repeat (9) step();
    sensor_garrafa = 1'b1;
    repeat (3) step();
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL align_3: estado=%0d expected 1", estado); end
    step();
    checks++; if (estado !== 3'd2 || motor_esteira !== 1'b0) begin errors++; $display("FAIL check_entry: estado=%0d motor=%b expected 2/0", estado, motor_esteira); end
    finish_bottle();
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL back_to_move: estado=%0d expected 1", estado); end
    checks++; if (garrafas !== 8'd1) begin errors++; $display("FAIL garrafas_1: got %0d expected 1", garrafas); end
  endtask

  task automatic test_glitch();
    logic [7:0] pat;
    pat = 8'b1110_1111;
    for (int i = 7; i >= 0; i--) begin
      sensor_garrafa = pat[i];
      step();
      if (i > 0) begin
        checks++; if (estado !== 3'd1 || tampar !== 1'b0) begin errors++; $display("FAIL glitch_early_%0d: estado=%0d tampar=%b expected 1/0", i, estado, tampar); end
      end
    end
    checks++; if (estado !== 3'd2) begin errors++; $display("FAIL glitch_check: estado=%0d expected 2", estado); end
    finish_bottle();
    checks++; if (garrafas !== 8'd2) begin errors++; $display("FAIL garrafas_2: got %0d expected 2", garrafas); end
  endtask

  task automatic test_no_cork();
    TemR = 1'b0;
    sensor_garrafa = 1'b1;
    repeat (4) step();
    checks++; if (estado !== 3'd2) begin errors++; $display("FAIL nc_check: estado=%0d expected 2", estado); end
    step();
    run = 1'b0;
    for (int i = 0; i < 20; i++) begin
      checks++; if (estado !== 3'd6 || sem_rolha !== 1'b1 || motor_esteira !== 1'b0 || tampar !== 1'b0) begin errors++; $display("FAIL nc_wait_%0d: estado=%0d sem_rolha=%b motor=%b tampar=%b expected 6/1/0/0", i, estado, sem_rolha, motor_esteira, tampar); end
      step();
    end
    TemR = 1'b1;
    step();
    checks++; if (estado !== 3'd3 || tampar !== 1'b1 || sem_rolha !== 1'b0) begin errors++; $display("FAIL nc_cap: estado=%0d tampar=%b sem_rolha=%b expected 3/1/0", estado, tampar, sem_rolha); end
    step();
    checks++; if (garrafas !== 8'd3) begin errors++; $display("FAIL garrafas_3: got %0d expected 3", garrafas); end
    repeat (7) step();
    step();
    checks++; if (estado !== 3'd5) begin errors++; $display("FAIL nc_release: estado=%0d expected 5", estado); end
    sensor_garrafa = 1'b0;
    step();
    checks++; if (estado !== 3'd0) begin errors++; $display("FAIL nc_idle: estado=%0d expected 0", estado); end
  endtask

  task automatic test_timeout();
    run = 1'b1;
    step();
    repeat (199) step();
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL to_before: estado=%0d expected 1", estado); end
    step();
    checks++; if (estado !== 3'd7 || falha !== 1'b1 || motor_esteira !== 1'b0) begin errors++; $display("FAIL to_fault: estado=%0d falha=%b motor=%b expected 7/1/0", estado, falha, motor_esteira); end
    repeat (5) step();
    checks++; if (estado !== 3'd7) begin errors++; $display("FAIL to_sticky: estado=%0d expected 7", estado); end
    clr_falha = 1'b1;
    step();
    clr_falha = 1'b0; run = 1'b0;
    checks++; if (estado !== 3'd0 || falha !== 1'b0) begin errors++; $display("FAIL to_clear: estado=%0d falha=%b expected 0/0", estado, falha); end
  endtask

  task automatic test_nivel();
    run = 1'b1; nivel_ok = 1'b0;
    step();
    sensor_garrafa = 1'b1;
    repeat (4) step();
    checks++; if (estado !== 3'd2) begin errors++; $display("FAIL nv_check: estado=%0d expected 2", estado); end
`ifdef REJECT_UNFILLED_EN
    step();
    checks++; if (estado !== 3'd5 || tampar !== 1'b0) begin errors++; $display("FAIL nv_reject: estado=%0d tampar=%b expected 5/0", estado, tampar); end
    checks++; if (garrafas !== 8'd3 || rejeitadas !== 8'd1) begin errors++; $display("FAIL nv_counts: garrafas=%0d rejeitadas=%0d expected 3/1", garrafas, rejeitadas); end
    sensor_garrafa = 1'b0;
    step();
`else
    finish_bottle();
    checks++; if (garrafas !== 8'd4) begin errors++; $display("FAIL nv_ignored: garrafas=%0d expected 4", garrafas); end
`endif
    nivel_ok = 1'b1;
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL nv_move: estado=%0d expected 1", estado); end
  endtask

  task automatic test_reset_mid_cap();
    reset = 1'b1;
    step();
    reset = 1'b0; run = 1'b1; TemR = 1'b1; sensor_garrafa = 1'b0;
    step();
    sensor_garrafa = 1'b1;
    repeat (4) step();
    step();
    checks++; if (tampar !== 1'b1 || garrafas !== 8'd0) begin errors++; $display("FAIL rm_cap: tampar=%b garrafas=%0d expected 1/0", tampar, garrafas); end
    reset = 1'b1;
    #1;
    checks++; if (tampar !== 1'b0 || estado !== 3'd0 || garrafas !== 8'd0) begin errors++; $display("FAIL rm_async: tampar=%b estado=%0d garrafas=%0d expected 0/0/0", tampar, estado, garrafas); end
    sensor_garrafa = 1'b0;
    step();
    reset = 1'b0;
    step();
    checks++; if (garrafas !== 8'd0) begin errors++; $display("FAIL rm_no_inc: garrafas=%0d expected 0", garrafas); end
  endtask

  task automatic test_back_to_back();
    int base;
    base = tampar_cnt;
    step();
    for (int b = 0; b < 256; b++) begin
      sensor_garrafa = 1'b1;
      repeat (4) step();
      finish_bottle();
      if (b == 254) begin
        checks++; if (garrafas !== 8'd255) begin errors++; $display("FAIL b2b_255: garrafas=%0d expected 255", garrafas); end
      end
    end
    checks++; if (garrafas !== 8'd0) begin errors++; $display("FAIL b2b_wrap: garrafas=%0d expected 0", garrafas); end
    checks++; if (tampar_cnt - base !== 256) begin errors++; $display("FAIL b2b_pulses: got %0d expected 256", tampar_cnt - base); end
    checks++; if (double_cnt !== 0) begin errors++; $display("FAIL b2b_double: got %0d expected 0", double_cnt); end
    checks++; if (overlap_cnt !== 0) begin errors++; $display("FAIL b2b_overlap: got %0d expected 0", overlap_cnt); end
    checks++; if (estado !== 3'd1) begin errors++; $display("FAIL b2b_move: estado=%0d expected 1", estado); end
  endtask

  initial begin
    test_reset();
    test_basic_cap();
    test_glitch();
    test_no_cork();
    test_timeout();
    test_nivel();
    test_reset_mid_cap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
